// File: rtl/lr_arbiter.sv
// lr_arbiter: round-robin front end that lets N_REQ requesters share one
// leaky-ReLU child. Each grant carries its requester index down a 2-stage tag
// pipeline so the child's result can be routed back to the owner. Holds one
// leak factor per requester. A flush drains in-flight work (RUN->DRAIN->DONE).
//
// Handshake: req_ready[i] is a combinational response to req_valid[i]; an
// operand is consumed in any cycle where req_valid[i] && req_ready[i]. Results
// have no backpressure: res_valid is a one-cycle strobe that must be taken.
//
// Optional feature: define LR_ARBITER_STATS_EN to get per-requester 16-bit
// saturating grant counters on stat_cnt; otherwise stat_cnt is tied to 0.
module lr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    localparam int SEL_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    cfg_we,
    input  logic [SEL_W-1:0]        cfg_sel,
    input  logic [DATA_W-1:0]       cfg_leak,
    output logic                    lr_valid_in,
    output logic [DATA_W-1:0]       lr_data_in,
    output logic [DATA_W-1:0]       lr_leak_factor_in,
    input  logic                    lr_valid_out,
    input  logic [DATA_W-1:0]       lr_data_out,
    output logic [N_REQ-1:0]        res_valid,
    output logic [DATA_W-1:0]       res_data,
    input  logic                    flush_req,
    output logic                    flush_done,
    output logic                    busy,
    output logic [N_REQ*16-1:0]     stat_cnt
);

    // Leak storage is sized to the full cfg_sel range; entries at or above
    // N_REQ can be written but are never read, so such writes have no effect.
    localparam int LEAK_N = 1 << SEL_W;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [DATA_W-1:0]   leak_q [LEAK_N];
    logic [DATA_W-1:0]   leak_d [LEAK_N];
    logic                lr_valid_q, lr_valid_d;
    logic [DATA_W-1:0]   lr_data_q, lr_data_d;
    logic [DATA_W-1:0]   lr_leak_q, lr_leak_d;
    logic                tag1_valid_q, tag1_valid_d;
    logic [SEL_W-1:0]    tag1_idx_q, tag1_idx_d;
    logic                tag2_valid_q, tag2_valid_d;
    logic [SEL_W-1:0]    tag2_idx_q, tag2_idx_d;

    logic                grant_en;
    logic                gnt_any;
    logic [SEL_W-1:0]    gnt_idx;
    logic [DATA_W-1:0]   gnt_data;
    logic                drain_idle;

    // Round-robin search starting at ptr_q; grants are blocked outside RUN,
    // on a flush request cycle, and while reset is held.
    always_comb begin
        int               cand;
        int               nxt;
        logic [SEL_W-1:0] cand_idx;
        cand      = 0;
        nxt       = 0;
        cand_idx  = '0;
        grant_en  = rst && (state_q == ST_RUN) && !flush_req;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = SEL_W'(cand);
            if (grant_en && !gnt_any && req_valid[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx;
            end
        end
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
        gnt_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
        ptr_d    = ptr_q;
        if (gnt_any) begin
            nxt = int'(gnt_idx) + 1;
            if (nxt == N_REQ) begin
                nxt = 0;
            end
            ptr_d = SEL_W'(nxt);
        end
    end

    // Child drive stage, tag pipeline and leak-factor writes. The grant reads
    // leak_q before the same-cycle write lands, so it sees the old factor.
    always_comb begin
        lr_valid_d   = gnt_any;
        lr_data_d    = gnt_any ? gnt_data : '0;
        lr_leak_d    = gnt_any ? leak_q[gnt_idx] : '0;
        tag1_valid_d = gnt_any;
        tag1_idx_d   = gnt_idx;
        tag2_valid_d = tag1_valid_q;
        tag2_idx_d   = tag1_idx_q;
        leak_d       = leak_q;
        if (cfg_we) begin
            leak_d[cfg_sel] = cfg_leak;
        end
    end

    // Drain is complete once stage 1 is empty: whatever sits in stage 2
    // retires this cycle, so DONE lands one cycle after the last result.
    // A result with no owning tag (e.g. from before a reset) also holds off DONE.
    assign drain_idle = !tag1_valid_q && (tag2_valid_q || !lr_valid_out);

    // Flush FSM next-state and flush_done decode.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_idle) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                flush_done = 1'b1;
                state_d    = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Combinational result routing to the requester named by the stage-2 tag.
    always_comb begin
        res_valid = '0;
        res_data  = '0;
        if (lr_valid_out && tag2_valid_q) begin
            res_valid[tag2_idx_q] = 1'b1;
            res_data              = lr_data_out;
        end
    end

    assign busy              = tag1_valid_q | tag2_valid_q;
    assign lr_valid_in       = lr_valid_q;
    assign lr_data_in        = lr_data_q;
    assign lr_leak_factor_in = lr_leak_q;

    // State registers; reset empties the tag pipeline so in-flight work is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            ptr_q        <= '0;
            leak_q       <= '{default: '0};
            lr_valid_q   <= 1'b0;
            lr_data_q    <= '0;
            lr_leak_q    <= '0;
            tag1_valid_q <= 1'b0;
            tag1_idx_q   <= '0;
            tag2_valid_q <= 1'b0;
            tag2_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            leak_q       <= leak_d;
            lr_valid_q   <= lr_valid_d;
            lr_data_q    <= lr_data_d;
            lr_leak_q    <= lr_leak_d;
            tag1_valid_q <= tag1_valid_d;
            tag1_idx_q   <= tag1_idx_d;
            tag2_valid_q <= tag2_valid_d;
            tag2_idx_q   <= tag2_idx_d;
        end
    end

`ifdef LR_ARBITER_STATS_EN
    logic [15:0] stat_q [N_REQ];
    logic [15:0] stat_d [N_REQ];

    // Saturating per-requester grant counters, cleared when a flush completes.
    always_comb begin
        stat_d = stat_q;
        if (state_q == ST_DONE) begin
            stat_d = '{default: '0};
        end else if (gnt_any && (stat_q[gnt_idx] != 16'hFFFF)) begin
            stat_d[gnt_idx] = stat_q[gnt_idx] + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= '{default: '0};
        end else begin
            stat_q <= stat_d;
        end
    end

    // Pack counters onto the flat stat_cnt bus, requester i in slice i.
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            stat_cnt[i*16 +: 16] = stat_q[i];
        end
    end
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_lr_arbiter.sv
// Directed testbench for lr_arbiter (N_REQ=4, DATA_W=16) with a behavioural
// leaky-ReLU child: one-cycle registered, negative inputs scaled by a Q8.8
// leak factor. Define LR_ARBITER_STATS_EN to exercise the grant counters.
module tb_lr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_leak;
  logic        lr_valid_in;
  logic [15:0] lr_data_in;
  logic [15:0] lr_leak_factor_in;
  logic        lr_valid_out = 1'b0;
  logic [15:0] lr_data_out = '0;
  logic [3:0]  res_valid;
  logic [15:0] res_data;
  logic        flush_req;
  logic        flush_done;
  logic        busy;
  logic [63:0] stat_cnt;

  int vectors = 0;
  int miscompares = 0;

  lr_arbiter #(.N_REQ(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_leak(cfg_leak),
    .lr_valid_in(lr_valid_in), .lr_data_in(lr_data_in),
    .lr_leak_factor_in(lr_leak_factor_in),
    .lr_valid_out(lr_valid_out), .lr_data_out(lr_data_out),
    .res_valid(res_valid), .res_data(res_data),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
    .stat_cnt(stat_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [15:0] child_f(input logic [15:0] x, input logic [15:0] k);
    logic signed [31:0] p;
    p = $signed(x) * $signed(k);
    return x[15] ? p[23:8] : x;
  endfunction

  // child model: not reset, so a pre-reset operation can still emerge
  always @(posedge clk) begin
    lr_valid_out <= lr_valid_in;
    lr_data_out  <= child_f(lr_data_in, lr_leak_factor_in);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_data = '0; cfg_we = 1'b0; cfg_sel = '0;
    cfg_leak = '0; flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset state, with requests pending
    req_valid = 4'hF; #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_lr_valid", lr_valid_in, 0);
    chk("rst_lr_data", lr_data_in, 0);
    chk("rst_lr_leak", lr_leak_factor_in, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_stat", stat_cnt, 0);
    req_valid = '0; rst = 1'b1;
    cyc();

    // leak[1]=0x0040, requester 1 operand 0xFF00 (-1.0) -> -0.25 = 0xFFC0
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_leak = 16'h0040;
    cyc();
    cfg_we = 1'b0;
    req_valid = 4'b0010; req_data[31:16] = 16'hFF00; #1;
    chk("t1_ready", req_ready, 4'b0010);
    cyc();
    req_valid = '0; #1;
    chk("t1_lr_valid", lr_valid_in, 1);
    chk("t1_lr_data", lr_data_in, 16'hFF00);
    chk("t1_lr_leak", lr_leak_factor_in, 16'h0040);
    chk("t1_busy", busy, 1);
    chk("t1_res_early", res_valid, 0);
    cyc(); #1;
    chk("t1_res_valid", res_valid, 4'b0010);
    chk("t1_res_data", res_data, 16'hFFC0);
    chk("t1_lr_idle", lr_valid_in, 0);
    cyc(); #1;
    chk("t1_res_clear", res_valid, 0);
    chk("t1_res_data0", res_data, 0);
    chk("t1_busy_clear", busy, 0);

    // reset while an operation is in flight (pointer is now 2)
    req_valid = 4'b1000; req_data[63:48] = 16'h0005; #1;
    chk("t5_ready", req_ready, 4'b1000);
    cyc();
    req_valid = '0; #1;
    chk("t5_lr_valid", lr_valid_in, 1);
    cyc();
    rst = 1'b0; #1;
    chk("t5_res_dropped", res_valid, 0);
    chk("t5_busy", busy, 0);
    cyc();
    rst = 1'b1;
    req_data = {16'h0400, 16'h0300, 16'h0200, 16'h0100};

    // continuous requests: pointer restarts at 0, full throughput
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0; #1;
      chk("t2_ready", req_ready, (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000);
      chk("t2_res_valid", res_valid, (k >= 2) ? (4'b0001 << ((k - 2) % 4)) : 4'b0000);
      chk("t2_res_data", res_data, (k >= 2) ? 16'(16'h0100 * ((k - 2) % 4 + 1)) : 16'h0000);
      cyc();
    end

    // leak write to 2 in the same cycle as a grant to 2 (pointer is 0)
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_leak = 16'h0010;
    req_valid = 4'b0100; req_data[47:32] = 16'hFE00; #1;
    chk("t3_ready_a", req_ready, 4'b0100);
    cyc();
    cfg_we = 1'b0; #1;
    chk("t3_old_leak", lr_leak_factor_in, 16'h0000);
    chk("t3_lr_data", lr_data_in, 16'hFE00);
    chk("t3_ready_b", req_ready, 4'b0100);
    cyc();
    req_valid = '0; #1;
    chk("t3_new_leak", lr_leak_factor_in, 16'h0010);
    chk("t3_res_a_valid", res_valid, 4'b0100);
    chk("t3_res_a_data", res_data, 16'h0000);
    cyc(); #1;
    chk("t3_res_b_valid", res_valid, 4'b0100);
    chk("t3_res_b_data", res_data, 16'hFFE0);
    cyc();

    // flush while streaming (pointer is 3)
    req_data[47:32] = 16'h0300;
    req_valid = 4'hF; #1;
    chk("t4_ready_s0", req_ready, 4'b1000);
    cyc(); #1;
    chk("t4_ready_s1", req_ready, 4'b0001);
    cyc();
    flush_req = 1'b1; #1;
    chk("t4_ready_flush", req_ready, 0);
    chk("t4_res_s0", res_valid, 4'b1000);
    chk("t4_busy", busy, 1);
    cyc();
    flush_req = 1'b0; #1;
    chk("t4_ready_drain", req_ready, 0);
    chk("t4_res_last", res_valid, 4'b0001);
    chk("t4_res_last_data", res_data, 16'h0100);
    chk("t4_done_early", flush_done, 0);
    cyc();
    flush_req = 1'b1; #1;
    chk("t4_flush_done", flush_done, 1);
    chk("t4_ready_done", req_ready, 0);
    chk("t4_res_done", res_valid, 0);
    chk("t4_busy_done", busy, 0);
    cyc();
    flush_req = 1'b0; #1;
    chk("t4_done_once", flush_done, 0);
    chk("t4_run_ready", req_ready, 4'b0010);
    cyc(); #1;
    chk("t4_no_redrain", flush_done, 0);
    chk("t4_run_ready2", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    cyc();
    cyc();

`ifdef LR_ARBITER_STATS_EN
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    cyc(); #1;
    chk("s_pre_done", flush_done, 1);
    cyc(); #1;
    chk("s_cleared", stat_cnt, 0);
    req_valid = 4'b0001;
    repeat (70000) cyc();
    req_valid = '0; #1;
    chk("s_sat0", stat_cnt[15:0], 16'hFFFF);
    chk("s_cnt1", stat_cnt[31:16], 16'h0000);
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    cyc(); #1;
    chk("s_done", flush_done, 1);
    cyc(); #1;
    chk("s_flush_clear", stat_cnt, 0);
`else
    chk("stat_off", stat_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
